// File: rtl/vend_dispenser.sv
// ---------------------------------------------------------------------------
// vend_dispenser
//
// Sequences one vend at a time:
//   product-release motor  ->  optional idle gap  ->  optional coin eject  ->  done.
// Requests that arrive while a vend is in progress wait in a 2-entry FIFO and
// are serviced in arrival order. A request that finds the FIFO full is dropped
// and sets a sticky overflow flag. An illegal change code sets a sticky error
// flag and is serviced as "no change". Every output comes straight from a flop.
//
// Parameters
//   MOTOR_CYC  cycles of motor drive per vend              (1..255)
//   GAP_CYC    idle cycles between motor and coin eject    (1..255)
//   EJECT_CYC  cycles of ejector drive                     (1..255)
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous reset, active-high
//   out       in   vend request strobe, one request per cycle sampled high
//   change    in   [1:0] change code qualified by out: 00 none, 01 5-unit,
//                  10 10-unit, 11 illegal
//   motor     out  product-release motor drive
//   eject5    out  5-unit coin ejector drive
//   eject10   out  10-unit coin ejector drive
//   busy      out  a vend is in progress or a request is pending
//   done      out  one-cycle pulse when a vend completes
//   overflow  out  sticky: a request was dropped
//   err       out  sticky: an illegal change code was accepted
// ---------------------------------------------------------------------------
module vend_dispenser #(
    parameter int MOTOR_CYC = 20,
    parameter int GAP_CYC   = 4,
    parameter int EJECT_CYC = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       out,
    input  logic [1:0] change,
    output logic       motor,
    output logic       eject5,
    output logic       eject10,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MOTOR = 3'd1,
        ST_GAP   = 3'd2,
        ST_EJECT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Phase counters count down from CYC-1 to 0, so a phase lasts exactly CYC cycles.
    localparam logic [7:0] MOTOR_LD = 8'(MOTOR_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);
    localparam logic [7:0] EJECT_LD = 8'(EJECT_CYC - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_5    = 2'b01;
    localparam logic [1:0] CODE_10   = 2'b10;
    localparam logic [1:0] CODE_ILL  = 2'b11;

    // The illegal code is serviced as "no change", so the FIFO and the
    // active-code register only ever hold 00, 01 or 10.
    function automatic logic [1:0] svc_code(input logic [1:0] c);
        return (c == CODE_ILL) ? CODE_NONE : c;
    endfunction

    // FSM and phase state
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  code_q, code_d;

    // Pending-request FIFO
    logic [1:0]  mem_q [0:1];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  lvl_q, lvl_d;

    // Registered outputs
    logic        motor_q, motor_d;
    logic        eject5_q, eject5_d;
    logic        eject10_q, eject10_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overflow_q, overflow_d;
    logic        err_q, err_d;

    // Request handling
    logic        fifo_empty;
    logic        fifo_full;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        drop;
    logic        accept;

    always_comb begin
        fifo_empty = (lvl_q == 2'd0);
        fifo_full  = (lvl_q == 2'd2);
        // A pop only happens from IDLE; it frees a slot at the same edge, so
        // a push arriving together with a pop is always accepted.
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        bypass     = (state_q == ST_IDLE) && fifo_empty && out;
        push       = out && !bypass && (!fifo_full || pop);
        drop       = out && !bypass && fifo_full && !pop;
        accept     = bypass || push;
    end

    // FIFO bookkeeping
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        lvl_d    = lvl_q;
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + 2'd1;
            2'b01:   lvl_d = lvl_q - 2'd1;
            default: lvl_d = lvl_q;
        endcase
    end

    // Next-state and phase counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    state_d = ST_MOTOR;
                    cnt_d   = MOTOR_LD;
                    code_d  = mem_q[rd_ptr_q];
                end else if (bypass) begin
                    state_d = ST_MOTOR;
                    cnt_d   = MOTOR_LD;
                    code_d  = svc_code(change);
                end
            end
            ST_MOTOR: begin
                if (cnt_q == 8'd0) begin
                    if (code_q == CODE_5 || code_q == CODE_10) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = ST_DONE;
                        cnt_d   = 8'd0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_EJECT;
                    cnt_d   = EJECT_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_EJECT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_DONE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the flops present
    // them in the same cycle the FSM occupies that state.
    always_comb begin
        motor_d    = (state_d == ST_MOTOR);
        eject5_d   = (state_d == ST_EJECT) && (code_d == CODE_5);
        eject10_d  = (state_d == ST_EJECT) && (code_d == CODE_10);
        done_d     = (state_d == ST_DONE);
        busy_d     = (state_d != ST_IDLE) || (lvl_d != 2'd0);
        overflow_d = overflow_q || drop;
        err_d      = err_q || (accept && (change == CODE_ILL));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            code_q     <= CODE_NONE;
            mem_q[0]   <= CODE_NONE;
            mem_q[1]   <= CODE_NONE;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            lvl_q      <= 2'd0;
            motor_q    <= 1'b0;
            eject5_q   <= 1'b0;
            eject10_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            if (push) begin
                mem_q[wr_ptr_q] <= svc_code(change);
            end
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            lvl_q      <= lvl_d;
            motor_q    <= motor_d;
            eject5_q   <= eject5_d;
            eject10_q  <= eject10_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    assign motor    = motor_q;
    assign eject5   = eject5_q;
    assign eject10  = eject10_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign err      = err_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// ---------------------------------------------------------------------------
// tb_vend_dispenser
//
// Directed scenarios followed by a randomized run. The reference model keeps
// a queue of pending change codes and, when a vend starts, expands it into a
// per-cycle script of expected drive values (motor run, gap, eject, done).
// Idle is simply "script empty".
// ---------------------------------------------------------------------------
module tb_vend_dispenser;

    localparam int MOTOR_CYC = 20;
    localparam int GAP_CYC   = 4;
    localparam int EJECT_CYC = 10;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       out    = 1'b0;
    logic [1:0] change = 2'b00;
    logic       motor, eject5, eject10, busy, done, overflow, err;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // Reference model state: script entries are {motor, eject5, eject10, done}
    logic [3:0] script[$];
    logic [1:0] pending[$];
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;

    vend_dispenser #(
        .MOTOR_CYC (MOTOR_CYC),
        .GAP_CYC   (GAP_CYC),
        .EJECT_CYC (EJECT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out      (out),
        .change   (change),
        .motor    (motor),
        .eject5   (eject5),
        .eject10  (eject10),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Expand one vend into its cycle-by-cycle drive pattern.
    task automatic start_service(input logic [1:0] code);
        for (int i = 0; i < MOTOR_CYC; i++) script.push_back(4'b1000);
        if (code == 2'b01 || code == 2'b10) begin
            for (int i = 0; i < GAP_CYC; i++) script.push_back(4'b0000);
            for (int i = 0; i < EJECT_CYC; i++)
                script.push_back((code == 2'b01) ? 4'b0100 : 4'b0010);
        end
        script.push_back(4'b0001);
    endtask

    task automatic enqueue(input logic [1:0] c);
        pending.push_back(c);
        if (c == 2'b11) m_err = 1'b1;
    endtask

    // Advance the model by one clock edge with request inputs o/c.
    task automatic model_edge(input logic o, input logic [1:0] c);
        bit was_busy;
        was_busy = (script.size() != 0);
        if (was_busy) begin
            void'(script.pop_front());
            if (o) begin
                if (pending.size() < 2) enqueue(c);
                else m_ovf = 1'b1;
            end
        end else if (pending.size() != 0) begin
            start_service(pending.pop_front());
            if (o) enqueue(c);
        end else if (o) begin
            start_service(c);
            if (c == 2'b11) m_err = 1'b1;
        end
    endtask

    task automatic model_clear();
        script.delete();
        pending.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] e;
        e = (script.size() != 0) ? script[0] : 4'b0000;
        check({tag, ".motor"},    motor,    e[3]);
        check({tag, ".eject5"},   eject5,   e[2]);
        check({tag, ".eject10"},  eject10,  e[1]);
        check({tag, ".done"},     done,     e[0]);
        check({tag, ".busy"},     busy,     (script.size() != 0) || (pending.size() != 0));
        check({tag, ".overflow"}, overflow, m_ovf);
        check({tag, ".err"},      err,      m_err);
    endtask

    // Called at posedge+1; drives inputs, takes one edge, checks at posedge+1.
    task automatic step(input logic o, input logic [1:0] c, input string tag);
        out    = o;
        change = c;
        @(posedge clk);
        model_edge(o, c);
        #1;
        out    = 1'b0;
        change = 2'b00;
        check_outputs(tag);
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic run_until_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (script.size() == 0 && pending.size() == 0) break;
            step(1'b0, 2'b00, tag);
        end
    endtask

    // Mid-cycle asynchronous reset, with a request held during reset.
    task automatic do_reset(input string tag);
        rst    = 1'b1;
        out    = 1'b1;
        change = 2'b11;
        #2;
        model_clear();
        check_outputs({tag, ".async"});
        @(posedge clk);
        #1;
        check_outputs({tag, ".hold"});
        rst    = 1'b0;
        out    = 1'b0;
        change = 2'b00;
    endtask

    initial begin
        // Power-on reset with a request present that must be ignored
        out    = 1'b1;
        change = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        check_outputs("por");
        rst    = 1'b0;
        out    = 1'b0;
        change = 2'b00;
        step(1'b0, 2'b00, "idle");

        // Single vend, no change
        step(1'b1, 2'b00, "r031");
        run_until_idle("r031");
        step(1'b0, 2'b00, "r031.after");

        // Single vend with a 10-unit coin
        step(1'b1, 2'b10, "r032");
        run_until_idle("r032");

        // Four back-to-back requests: one served, two queued, one dropped
        done_cnt = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, "r033");
        run_until_idle("r033");
        check("r033.ovf_final", overflow, 1'b1);
        check("r033.done_pulses", done_cnt, 3);
        do_reset("rst1");

        // Illegal code: err next cycle, motor-only vend, err sticky
        step(1'b1, 2'b11, "r034");
        run_until_idle("r034");
        repeat (3) step(1'b0, 2'b00, "r034.idle");
        check("r034.err_sticky", err, 1'b1);
        do_reset("rst2");

        // Reset in the middle of an eject with one request queued
        step(1'b1, 2'b01, "r035");
        step(1'b1, 2'b10, "r035.q");
        for (int i = 0; i < 100; i++) begin
            if (script.size() != 0 && script[0] == 4'b0100) break;
            step(1'b0, 2'b00, "r035.run");
        end
        step(1'b0, 2'b00, "r035.eject");
        step(1'b0, 2'b00, "r035.eject");
        do_reset("r035.rst");
        for (int i = 0; i < 60; i++) step(1'b0, 2'b00, "r035.post");

        // Push in the IDLE pop cycle with one entry pending
        step(1'b1, 2'b00, "r036");
        step(1'b1, 2'b01, "r036.q");
        for (int i = 0; i < 100; i++) begin
            if (script.size() == 0) break;
            step(1'b0, 2'b00, "r036.run");
        end
        step(1'b1, 2'b10, "r036.pop_push");
        run_until_idle("r036.tail");
        check("r036.no_ovf", overflow, 1'b0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset("rand.rst");
            end else begin
                step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), "rand");
            end
        end
        run_until_idle("rand.tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 Parameter MOTOR_CYC, default 20, is the number of cycles product-release motor drive is held; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 4, is the number of idle cycles between motor drive and coin eject; legal range 1..255.
REQ-003 Parameter EJECT_CYC, default 10, is the number of cycles coin-eject solenoid drive is held; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 out  input  1  vend request strobe; one request per cycle sampled high.
REQ-007 change  input  2  change code, qualified by out: 00 none, 01 one 5-unit coin, 10 one 10-unit coin, 11 illegal.
REQ-008 motor  output  1  product-release motor drive.
REQ-009 eject5  output  1  5-unit coin ejector drive.
REQ-010 eject10  output  1  10-unit coin ejector drive.
REQ-011 busy  output  1  high while a request is in service or pending.
REQ-012 done  output  1  one-cycle pulse at completion of each request.
REQ-013 overflow  output  1  sticky flag: a request was dropped.
REQ-014 err  output  1  sticky flag: an illegal change code was accepted.

Function
REQ-015 All outputs SHALL be registered; none SHALL depend combinationally on out or change.
REQ-016 The block SHALL implement states IDLE, MOTOR, GAP, EJECT, DONE.
REQ-017 A 2-entry FIFO SHALL hold pending change codes; an entry is written on every edge sampling out=1, unless bypassed (REQ-018) or full (REQ-023).
REQ-018 IDLE, FIFO empty, out=1 at edge n: request SHALL bypass the FIFO; state MOTOR from edge n, motor=1 in the cycle after edge n.
REQ-019 IDLE, FIFO non-empty: head SHALL be popped and MOTOR entered at the next edge; a simultaneous push at that edge is accepted.
REQ-020 MOTOR: motor=1 for exactly MOTOR_CYC cycles; then GAP if code is 01 or 10, else DONE.
REQ-021 GAP: all drives low for exactly GAP_CYC cycles, then EJECT.
REQ-022 EJECT: eject5=1 (code 01) or eject10=1 (code 10) for exactly EJECT_CYC cycles, then DONE; eject5 and eject10 SHALL never be high together.
REQ-023 A request arriving with 2 entries pending and no pop at that edge SHALL be dropped and SHALL set overflow=1.
REQ-024 Code 11 SHALL set err=1 at acceptance and be serviced as 00 (motor only).
REQ-025 DONE SHALL last one cycle with done=1 and all drives low, then IDLE.
REQ-026 busy SHALL be 1 whenever state is not IDLE or FIFO is non-empty, else 0.
REQ-027 Requests SHALL be serviced in arrival order; motor and ejector drives SHALL never overlap.
REQ-028 Phase counters SHALL be 8 bits and reload at each state entry; no wrap-around within a phase.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, FIFO empty, and motor, eject5, eject10, busy, done, overflow, err to 0, including mid-phase.
REQ-030 Requests with out=1 while rst=1 SHALL be ignored; overflow and err clear only by reset.

Verification
REQ-031 Reset, then out=1, change=00 for one cycle -> motor=1 for 20 cycles starting next cycle, done=1 the following cycle, no eject, busy low afterward.
REQ-032 out=1, change=10 -> motor 20 cycles, 4 cycles all low, eject10 10 cycles, done pulse; eject5 stays 0.
REQ-033 Four consecutive out=1 cycles, change=01 -> first serviced, two queued and serviced in order with eject5, fourth dropped, overflow=1, exactly three done pulses.
REQ-034 out=1, change=11 -> err=1 next cycle, motor 20 cycles, no eject, done pulse; err remains 1 until reset.
REQ-035 rst=1 during EJECT with one request queued -> all outputs 0 asynchronously, queued request never serviced after rst=0.
REQ-036 out=1 in IDLE-pop cycle with one entry pending -> both serviced back-to-back, one DONE cycle plus one IDLE cycle between them, no overflow.
